wb_gpio: RTL
============

# wb_gpio

Parametrised Wishbone GPIO peripheral replacing the fixed 4-bit, write-only pad register in the SoC top. Provides `NUM_PADS` bidirectional pads with per-bit direction, atomic set/clear, synchronised input readback, and per-bit rising/falling-edge interrupts. It sits on one interconnect slave port (4 KB window) and drives one line of the interrupt controller.

## Interface
- `NUM_PADS`, 32: number of pads, legal range 1..32. Register bits at `NUM_PADS` and above read 0 and ignore writes.
- `SYNC_STAGES`, 2: input synchroniser depth, legal range 2..4.
- `RESET_OUT`, 0: reset value of DATA_OUT, `NUM_PADS` bits wide.
- `clk`, input, 1: the single clock. Every flop is on its rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `s`, `wb_if.slave`, 32/32: register port. Uses ADR[4:2], DAT_W, SEL, WE, CYC, STB. Returns DAT_R and ACK. ERR is tied 0.
- `pad_i`, input, NUM_PADS: raw pad inputs, asynchronous to `clk`.
- `pad_o`, output, NUM_PADS: equals DATA_OUT.
- `pad_oe`, output, NUM_PADS: equals DIR, where 1 means the pad drives.
- `irq`, output, 1: OR-reduction of IRQ_STATUS.

## Operation
Register map by word offset ADR[4:2]:
- 0 DATA_OUT: read/write.
- 1 DATA_IN: read-only; the synchronised `pad_i`.
- 2 DIR: read/write.
- 3 SET: write-only; DATA_OUT |= wdata. Reads return 0.
- 4 CLR: write-only; DATA_OUT &= ~wdata. Reads return 0.
- 5 RISE_EN: read/write.
- 6 FALL_EN: read/write.
- 7 IRQ_STATUS: read; write-1-to-clear.

Write rules:
- SEL byte lanes gate every write. A disabled lane neither modifies nor sets/clears/acknowledges any bit.
- Writes to DATA_IN have no effect.

Edge detection, per bit:
- `prev` holds the previous synchronised value.
- `rise = sync & ~prev & RISE_EN`.
- `fall = ~sync & prev & FALL_EN`.
- STATUS[i] is set when `rise[i] | fall[i]`.
- Detection works regardless of DIR, so an output pad can loop back and interrupt.
- If an edge set and a W1C clear hit the same bit in the same cycle, the set wins.
- Clearing RISE_EN/FALL_EN does not clear STATUS.

Reset values (`rstn` low, asynchronous):
- DATA_OUT = `RESET_OUT`.
- DIR, RISE_EN, FALL_EN, STATUS = 0.
- Synchronisers and `prev` = 0.
- ACK = 0, DAT_R = 0.
- Resulting outputs: `pad_oe` = 0, `pad_o` = `RESET_OUT`, `irq` = 0.

Post-reset guard:
- A counter suppresses edge detection for `SYNC_STAGES+1` cycles after `rstn` deasserts.
- A pad held high through reset therefore raises no spurious rising edge.
- `prev` still tracks the input during the guard.

Reset mid-transaction: ACK is dropped immediately and no register write completes.

## Timing
Bus handshake:
- A request is accepted at the rising edge E where CYC & STB & ~ACK is true.
- At E, the write commits and read data is registered into DAT_R.
- ACK is high for exactly one cycle, from after E until after E+1.
- Each access completes in 2 cycles. Back-to-back requests complete one every 2 cycles.
- CYC or STB dropping while ACK is high is legal; nothing is re-acknowledged.
- A read of DATA_OUT in the cycle after a SET returns the updated value.

Output timing: `pad_o` and `pad_oe` change right after E (registered outputs, zero extra latency).

Input path (pad change first sampled at edge P):
- DATA_IN shows the change for reads accepted at edge P+SYNC_STAGES or later.
- STATUS bit and `irq` rise right after edge P+SYNC_STAGES.
- Glitches shorter than one clock period may be missed. Pulses of at least 2 cycles must be detected.

W1C to STATUS takes effect at E. `irq` falls in the same cycle that ACK rises, unless a new edge sets the bit at E.

## Structure
- Package `wb_gpio_pkg` holds:
  - the register offset constants `GPIO_DATA_OUT` … `GPIO_IRQ_STATUS` (0..7);
  - the `SYNC_STAGES` legal range, checked by an elaboration-time assertion.
- Sub-module `gpio_edge_detect #(WIDTH, SYNC_STAGES)` contains the synchroniser chain, `prev`, the guard counter and the `rise`/`fall` vectors.
- The top level contains the register file, bus FSM and STATUS logic.
- Target size is about 200 lines of RTL.

## Test plan
- **Reset:** hold `pad_i`=32'hFFFF_FFFF through reset and set RISE_EN=all. Required: `irq` stays 0 for 20 cycles, DATA_IN reads 32'hFFFF_FFFF, `pad_oe`=0.
- **Set/clear:** write DATA_OUT=32'h0000_00F0, then SET=32'h0000_000F, then CLR=32'h0000_0030. Required: DATA_OUT reads 32'h0000_00CF, `pad_o` matches, each ACK is 1 cycle wide.
- **Byte lanes:** write DIR=32'hAABB_CCDD with SEL=4'b0101. Required: DIR reads 32'h00BB_00DD.
- **Edges:** set RISE_EN bit 3 and FALL_EN bit 5, then pulse `pad_i[3]` high for 2 cycles and drop `pad_i[5]`. Required:
  - STATUS=32'h28 and `irq`=1 exactly `SYNC_STAGES` edges after sampling;
  - W1C 32'h08 leaves STATUS=32'h20;
  - W1C 32'h20 drops `irq`.
- **Collision:** issue a W1C on bit 3 at the same edge a new rising edge on bit 3 is detected. Required: bit 3 remains 1.
- **Parameters:** build with `NUM_PADS`=4, `SYNC_STAGES`=3 and write 32'hFFFF_FFFF to DATA_OUT. Required: readback is 32'h0000_000F and input latency is 3 edges.

Source files
------------

// File: rtl/wb_gpio_pkg.sv
// Shared constants, bus FSM state type and helpers for the Wishbone GPIO block.
package wb_gpio_pkg;

    localparam logic [2:0] GPIO_DATA_OUT   = 3'd0;
    localparam logic [2:0] GPIO_DATA_IN    = 3'd1;
    localparam logic [2:0] GPIO_DIR        = 3'd2;
    localparam logic [2:0] GPIO_SET        = 3'd3;
    localparam logic [2:0] GPIO_CLR        = 3'd4;
    localparam logic [2:0] GPIO_RISE_EN    = 3'd5;
    localparam logic [2:0] GPIO_FALL_EN    = 3'd6;
    localparam logic [2:0] GPIO_IRQ_STATUS = 3'd7;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;
    localparam int unsigned NUM_PADS_MIN    = 1;
    localparam int unsigned NUM_PADS_MAX    = 32;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone 32/32 signal bundle with master and slave views.
interface wb_if;

    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err
    );

endinterface

// File: rtl/gpio_edge_detect.sv
// Pad input synchroniser, previous-value tracking and enable-gated edge detection
// with a post-reset guard that hides edges caused by the synchroniser filling up.
module gpio_edge_detect #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] pad_i,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned GUARD = SYNC_STAGES + 1;
    localparam int unsigned GW    = $clog2(GUARD + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [GW-1:0]                     guard_q;
    logic                              armed;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '0;
            prev_q  <= '0;
            guard_q <= GW'(GUARD);
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (guard_q != '0) begin
                guard_q <= guard_q - GW'(1);
            end
        end
    end

    // prev keeps tracking during the guard so the first armed cycle compares settled values
    assign armed   = (guard_q == '0);
    assign data_in = sync_q[SYNC_STAGES-1];
    assign rise    = data_in & ~prev_q & rise_en & {WIDTH{armed}};
    assign fall    = ~data_in & prev_q & fall_en & {WIDTH{armed}};

endmodule

// File: rtl/wb_gpio.sv
// Wishbone GPIO peripheral: data/direction registers, atomic set/clear,
// synchronised input readback and per-pad edge interrupts.
module wb_gpio
    import wb_gpio_pkg::*;
#(
    parameter int unsigned         NUM_PADS    = 32,
    parameter int unsigned         SYNC_STAGES = 2,
    parameter logic [NUM_PADS-1:0] RESET_OUT   = '0
) (
    input  logic                clk,
    input  logic                rstn,
    wb_if.slave                 s,
    input  logic [NUM_PADS-1:0] pad_i,
    output logic [NUM_PADS-1:0] pad_o,
    output logic [NUM_PADS-1:0] pad_oe,
    output logic                irq
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
        $error("wb_gpio: SYNC_STAGES out of range");
    end
    if (NUM_PADS < NUM_PADS_MIN || NUM_PADS > NUM_PADS_MAX) begin : g_bad_num_pads
        $error("wb_gpio: NUM_PADS out of range");
    end

    bus_state_e state_q, state_d;
    logic       accept;

    logic [31:0]         lanes;
    logic [31:0]         wd_full;
    logic [NUM_PADS-1:0] wmask;
    logic [NUM_PADS-1:0] wdata;
    logic [2:0]          off;
    logic                unused_bits;

    logic [NUM_PADS-1:0] data_out_q, dir_q, rise_en_q, fall_en_q, status_q;
    logic [NUM_PADS-1:0] data_in, rise, fall, w1c;
    logic [NUM_PADS-1:0] rd_pads;
    logic [31:0]         rd_data, dat_r_q;

    gpio_edge_detect #(
        .WIDTH       (NUM_PADS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk     (clk),
        .rstn    (rstn),
        .pad_i   (pad_i),
        .rise_en (rise_en_q),
        .fall_en (fall_en_q),
        .data_in (data_in),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ACK lasts one cycle; a request still held during ACK is not taken again
    always_comb begin
        state_d = BUS_IDLE;
        accept  = 1'b0;
        if (state_q == BUS_IDLE && s.cyc && s.stb) begin
            accept  = 1'b1;
            state_d = BUS_ACK;
        end
    end

    assign off         = s.adr[4:2];
    assign lanes       = lane_mask(s.sel);
    assign wd_full     = s.dat_w & lanes;
    assign wmask       = lanes[NUM_PADS-1:0];
    assign wdata       = wd_full[NUM_PADS-1:0];
    assign unused_bits = ^{s.adr[31:5], s.adr[1:0], wd_full, lanes};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out_q <= RESET_OUT;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
        end else if (accept && s.we) begin
            case (off)
                GPIO_DATA_OUT: data_out_q <= (data_out_q & ~wmask) | wdata;
                GPIO_DIR:      dir_q      <= (dir_q & ~wmask) | wdata;
                GPIO_SET:      data_out_q <= data_out_q | wdata;
                GPIO_CLR:      data_out_q <= data_out_q & ~wdata;
                GPIO_RISE_EN:  rise_en_q  <= (rise_en_q & ~wmask) | wdata;
                GPIO_FALL_EN:  fall_en_q  <= (fall_en_q & ~wmask) | wdata;
                default: ;
            endcase
        end
    end

    // new edges are OR-ed in after the clear so a colliding edge survives
    assign w1c = (accept && s.we && off == GPIO_IRQ_STATUS) ? wdata : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~w1c) | rise | fall;
        end
    end

    always_comb begin
        rd_pads = '0;
        case (off)
            GPIO_DATA_OUT:   rd_pads = data_out_q;
            GPIO_DATA_IN:    rd_pads = data_in;
            GPIO_DIR:        rd_pads = dir_q;
            GPIO_RISE_EN:    rd_pads = rise_en_q;
            GPIO_FALL_EN:    rd_pads = fall_en_q;
            GPIO_IRQ_STATUS: rd_pads = status_q;
            default:         rd_pads = '0;
        endcase
        rd_data = '0;
        rd_data[NUM_PADS-1:0] = rd_pads;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dat_r_q <= '0;
        end else if (accept) begin
            dat_r_q <= rd_data;
        end
    end

    assign s.ack   = (state_q == BUS_ACK);
    assign s.dat_r = dat_r_q;
    assign s.err   = 1'b0;
    assign pad_o   = data_out_q;
    assign pad_oe  = dir_q;
    assign irq     = |status_q;

endmodule
